// File: rtl/inv_round_column_seq.sv
// Column-serial inverse round: AddRoundKey on accept, then InvMixColumns one
// 32-bit column per cycle through a single shared column helper. On the final
// round the mix is skipped and the XOR-ed block is presented directly.

// Combinational InvMixColumns of one column; row 0 is the MSB byte.
module mix_column_helper (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Fixed-coefficient GF(2^8) products built from repeated doubling.
  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction
  function automatic logic [7:0] m11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction
  function automatic logic [7:0] m13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction
  function automatic logic [7:0] m14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;

  assign col_out[31:24] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
  assign col_out[23:16] = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
  assign col_out[15:8]  = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
  assign col_out[7:0]   = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
endmodule

module inv_round_column_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t       state;
  logic [127:0] st;
  logic [1:0]   col;
  logic [31:0]  col_cur;
  logic [31:0]  col_mix;

  // Select the column currently being mixed (column 0 is the MSB word).
  always_comb begin
    col_cur = st[127:96];
    case (col)
      2'd0: col_cur = st[127:96];
      2'd1: col_cur = st[95:64];
      2'd2: col_cur = st[63:32];
      2'd3: col_cur = st[31:0];
      default: col_cur = st[127:96];
    endcase
  end

  mix_column_helper u_mix (
    .col_in  (col_cur),
    .col_out (col_mix)
  );

  // Control FSM and datapath registers; reset wins over both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_state ^ in_key;
            col   <= '0;
            state <= in_last ? DONE : MIX;
          end
        end
        MIX: begin
          case (col)
            2'd0: st[127:96] <= col_mix;
            2'd1: st[95:64]  <= col_mix;
            2'd2: st[63:32]  <= col_mix;
            2'd3: st[31:0]   <= col_mix;
            default: ;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_state = st;
endmodule

// File: tb/tb_inv_round_column_seq.sv
// Directed bench for inv_round_column_seq: vector table plus hand-written
// backpressure, mid-mix reset and back-to-back sequences.
module tb_inv_round_column_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  always #5 clk = ~clk;

  inv_round_column_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  typedef struct {
    logic [127:0] s;
    logic [127:0] k;
    logic         last;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector, check latency and result, then complete the handshake.
  task automatic run_vec(input int i);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("in_ready_before_accept", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_state = vt[i].s;
    in_key   = vt[i].k;
    in_last  = vt[i].last;
    tick();
    in_valid = 1'b0;
    in_state = '1;
    in_key   = '1;
    in_last  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("latency[%0d]", i), 128'(lat), 128'(vt[i].lat));
    chk($sformatf("out_state[%0d]", i), out_state, vt[i].exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("in_ready_after_hs[%0d]", i), {127'b0, in_ready}, 128'd1);
    chk($sformatf("out_valid_after_hs[%0d]", i), {127'b0, out_valid}, 128'd0);
  endtask

  localparam logic [127:0] PURE_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] PURE_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] FIN_IN   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIN_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIN_OUT  = 128'h00102030405060708090a0b0c0d0e0f0;

  logic [127:0] exp_q[$];
  logic         last_q[$];

  initial begin
    // Columns whose four bytes are equal are fixed points of InvMixColumns.
    vt[0] = '{PURE_IN, 128'h0, 1'b0, PURE_OUT, 5};
    vt[1] = '{FIN_IN, FIN_KEY, 1'b1, FIN_OUT, 1};
    vt[2] = '{128'h71b25e43_6023a762_fefefefe_2a2a2829, '1, 1'b0, PURE_OUT, 5};
    vt[3] = '{128'h0, 128'h0, 1'b0, 128'h0, 5};
    vt[4] = '{128'haaaaaaaa_55555555_ffffffff_00000000, 128'h0, 1'b0,
              128'haaaaaaaa_55555555_ffffffff_00000000, 5};
    vt[5] = '{128'h0, '1, 1'b1, '1, 1};
    vt[6] = '{128'h0, PURE_IN, 1'b0, PURE_OUT, 5};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0;
    in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready", {127'b0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
    chk("reset_out_state", out_state, 128'h0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: hold DONE for 10 clocks while a new block is offered.
    in_valid = 1'b1; in_state = PURE_IN; in_key = '0; in_last = 1'b0;
    tick();
    in_state = FIN_IN; in_key = FIN_KEY; in_last = 1'b1;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      chk("bp_out_state", out_state, PURE_OUT);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_in_ready_after", {127'b0, in_ready}, 128'd1);
    chk("bp_st_kept", out_state, PURE_OUT);
    tick();
    chk("bp_no_accept", {127'b0, in_ready}, 128'd1);

    // Reset while column 2 is about to be mixed.
    in_valid = 1'b1; in_state = PURE_IN; in_key = '0; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("mid_rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("mid_rst_out_state", out_state, 128'h0);
    run_vec(0);

    // Back-to-back: alternate pure-mix and final-round blocks.
    begin
      int k, prev_cyc, n_acc, n_out;
      logic prev_last, have_prev, acc, hs;
      k = 0; prev_cyc = 0; n_acc = 0; n_out = 0;
      prev_last = 1'b0; have_prev = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = vt[0].s; in_key = vt[0].k; in_last = vt[0].last;
      for (int cyc = 0; cyc < 40; cyc++) begin
        acc = in_ready & in_valid;
        hs  = out_valid;
        if (hs) begin
          n_out++;
          if (exp_q.size() == 0) chk("b2b_spurious_out", out_state, 128'hx);
          else chk("b2b_out_state", out_state, exp_q.pop_front());
        end
        if (acc) begin
          if (have_prev)
            chk("b2b_spacing", 128'(cyc - prev_cyc), prev_last ? 128'd2 : 128'd6);
          prev_cyc  = cyc;
          prev_last = in_last;
          have_prev = 1'b1;
          exp_q.push_back((k % 2 == 0) ? vt[0].exp : vt[1].exp);
          n_acc++;
          k++;
        end
        tick();
        if (acc) begin
          in_state = (k % 2 == 0) ? vt[0].s    : vt[1].s;
          in_key   = (k % 2 == 0) ? vt[0].k    : vt[1].k;
          in_last  = (k % 2 == 0) ? vt[0].last : vt[1].last;
        end
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (out_valid) begin
          n_out++;
          if (exp_q.size() == 0) chk("b2b_spurious_out", out_state, 128'hx);
          else chk("b2b_out_state", out_state, exp_q.pop_front());
        end
        tick();
      end
      chk("b2b_out_count", 128'(n_out), 128'(n_acc));
      chk("b2b_enough_accepts", 128'(n_acc >= 8), 128'd1);
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
